// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // Canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // One prefetch-buffer entry: the fetch address and the word returned for it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush.
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write an entry (accepted when not full, or full with a pop)
//   pop          : drop the head entry (ignored when empty)
//   flush        : discard all entries; wins over push and pop
//   rdata        : head entry (meaningful only when not empty)
//   full, empty  : occupancy flags decoded from the entry count
module fetch_buffer
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rdata = mem[rd_ptr];

  // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Entry storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the fetch PC, reads the zero-latency
// instruction memory and queues words in a prefetch buffer for decode.
//   clk, reset                : clock, synchronous active-high reset
//   fetch_en                  : allow fetching (buffer drains regardless)
//   imem_addr / imem_data     : word address out, instruction word back same cycle
//   redirect_valid/_pc        : control-transfer target; flushes the buffer
//   inst_valid/_ready         : decode handshake on the buffer head
//   inst_data / inst_pc       : head word and its PC, zero when empty
module instr_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] ALIGN_MASK = ~32'(INSTR_BYTES - 1);

  logic [31:0]  fetch_pc;
  fetch_state_e state_q;
  fetch_state_e state_d;
  fetch_entry_t wr_entry;
  fetch_entry_t head;
  logic         buf_full;
  logic         buf_empty;
  logic         pop_c;
  logic         push_c;

  assign imem_addr  = fetch_pc;
  assign inst_valid = ~buf_empty;
  assign inst_data  = buf_empty ? '0 : head.instr;
  assign inst_pc    = buf_empty ? '0 : head.pc;

  assign pop_c  = inst_valid & inst_ready;
  assign push_c = fetch_en & ~redirect_valid & (~buf_full | pop_c);

  assign wr_entry = '{pc: fetch_pc, instr: imem_data};

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Fetch PC: reset > redirect (aligned) > sequential advance on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC & ALIGN_MASK;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
    end else if (push_c) begin
      fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // FSM next-state: mirrors buffer occupancy and fetch enable for visibility.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (!fetch_en)              state_d = HALT;
        else if (buf_full && !pop_c) state_d = STALL;
      end
      STALL: begin
        if (pop_c)          state_d = FETCH;
        else if (!fetch_en) state_d = HALT;
      end
      HALT: begin
        if (fetch_en) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid) state_d = FETCH;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (reset PC 0 and FFFF_FFF8) share stimulus
// and are compared every cycle against a queue-level model of the fetch stream.
module tb_instr_fetch;
  import cpu_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;

  logic [31:0] imem_addr [2];
  logic [31:0] imem_data [2];
  logic        inst_valid[2];
  logic [31:0] inst_data [2];
  logic [31:0] inst_pc   [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Model: fetch PC and an ordered list of buffered PCs per instance.
  logic [31:0] m_rpc [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_q   [2][DEPTH];
  int          m_cnt [2];
  bit          m_init = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign imem_data[0] = imem_addr[0] ^ KEY;
  assign imem_data[1] = imem_addr[1] ^ KEY;

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr[0]), .imem_data(imem_data[0]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid[0]), .inst_ready(inst_ready),
    .inst_data(inst_data[0]), .inst_pc(inst_pc[0])
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr[1]), .imem_data(imem_data[1]),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid[1]), .inst_ready(inst_ready),
    .inst_data(inst_data[1]), .inst_pc(inst_pc[1])
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
  endtask

  // Model update at the active edge from the inputs held through the cycle.
  always @(posedge clk) begin
    bit p, u;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_pc[i]  = m_rpc[i];
        m_cnt[i] = 0;
      end else if (redirect_valid) begin
        m_cnt[i] = 0;
        m_pc[i]  = {redirect_pc[31:2], 2'b00};
      end else begin
        p = (m_cnt[i] > 0) && inst_ready;
        u = fetch_en && ((m_cnt[i] < DEPTH) || p);
        if (p) begin
          for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
          m_cnt[i]--;
        end
        if (u) begin
          m_q[i][m_cnt[i]] = m_pc[i];
          m_cnt[i]++;
          m_pc[i] = m_pc[i] + 32'd4;
        end
      end
    end
    m_init = 1;
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 2; i++) begin
        chk("imem_addr", i, imem_addr[i], m_pc[i]);
        chk("inst_valid", i, 32'(inst_valid[i]), 32'(m_cnt[i] > 0));
        chk("inst_pc", i, inst_pc[i], (m_cnt[i] > 0) ? m_q[i][0] : 32'h0);
        chk("inst_data", i, inst_data[i], (m_cnt[i] > 0) ? (m_q[i][0] ^ KEY) : 32'h0);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    m_rpc[0] = 32'h0000_0000;
    m_rpc[1] = 32'hFFFF_FFF8;
    reset = 1; fetch_en = 1; inst_ready = 1; redirect_valid = 0; redirect_pc = '0;

    // Streaming from reset, including PC wrap on the second instance.
    cyc();
    chk("rst_addr", 0, imem_addr[0], 32'h0);
    chk("rst_addr", 1, imem_addr[1], 32'hFFFF_FFF8);
    chk("rst_valid", 0, 32'(inst_valid[0]), 32'h0);
    chk("rst_data", 0, inst_data[0], 32'h0);
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("stream_pc", 0, inst_pc[0], 32'(4 * k));
      chk("stream_data", 0, inst_data[0], 32'(4 * k) ^ KEY);
      chk("wrap_pc", 1, inst_pc[1], 32'hFFFF_FFF8 + 32'(4 * k));
    end

    // Backpressure: buffer fills, fetch stalls, then drains in order.
    reset = 1; inst_ready = 0;
    cyc();
    reset = 0;
    cyc(5);
    chk("stall_addr", 0, imem_addr[0], 32'h8);
    chk("stall_pc", 0, inst_pc[0], 32'h0);
    inst_ready = 1;
    chk("drain_pc0", 0, inst_pc[0], 32'h0);
    cyc();
    chk("drain_pc1", 0, inst_pc[0], 32'h4);
    cyc();
    chk("drain_pc2", 0, inst_pc[0], 32'h8);

    // Redirect on a full buffer with a concurrent ready discards the pop.
    reset = 1; inst_ready = 0;
    cyc();
    reset = 0;
    cyc(2);
    chk("full_head", 0, inst_pc[0], 32'h0);
    redirect_valid = 1; redirect_pc = 32'h30; inst_ready = 1;
    cyc();
    redirect_valid = 0;
    chk("redir_valid", 0, 32'(inst_valid[0]), 32'h0);
    chk("redir_addr", 0, imem_addr[0], 32'h30);
    cyc();
    chk("redir_pc", 0, inst_pc[0], 32'h30);

    // Misaligned redirect target is aligned down.
    redirect_valid = 1; redirect_pc = 32'h0000_0033;
    cyc();
    redirect_valid = 0;
    chk("align_addr", 0, imem_addr[0], 32'h30);
    cyc();
    chk("align_pc", 0, inst_pc[0], 32'h30);
    chk("align_data", 0, inst_data[0], 32'h30 ^ KEY);

    // Reset mid-stream with a full buffer and toggling fetch_en, then hold.
    inst_ready = 0;
    cyc(3);
    fetch_en = 0; cyc();
    fetch_en = 1; cyc();
    reset = 1; fetch_en = 0;
    cyc();
    chk("mrst_valid", 0, 32'(inst_valid[0]), 32'h0);
    chk("mrst_data", 0, inst_data[0], 32'h0);
    chk("mrst_pc", 0, inst_pc[0], 32'h0);
    chk("mrst_addr", 1, imem_addr[1], 32'hFFFF_FFF8);
    reset = 0; fetch_en = 0; inst_ready = 1;
    cyc(3);
    chk("halt_addr", 0, imem_addr[0], 32'h0);
    chk("halt_valid", 0, 32'(inst_valid[0]), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      reset          = ($urandom_range(0, 99) < 2);
      fetch_en       = ($urandom_range(0, 99) < 80);
      inst_ready     = ($urandom_range(0, 99) < 65);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      cyc();
    end

    reset = 0; redirect_valid = 0;
    @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
